// File: rtl/shift_rx.sv
// shift_rx: serial frame receiver (start, 8 data MSB/LSB-first, even parity, stop) to parallel byte.
module shift_rx (
  input  logic       clk,
  input  logic       clr,
  input  logic       sin,
  input  logic       en,
  input  logic       dir,
  output logic [7:0] dout,
  output logic       valid,
  output logic       perr,
  output logic       ferr,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t     state_q, state_d;
  logic [7:0] sr_q, sr_d, dout_q, dout_d;
  logic [2:0] cnt_q, cnt_d;
  logic       ord_q, ord_d, par_q, par_d, valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      sr_q    <= 8'h00;
      cnt_q   <= 3'd0;
      ord_q   <= 1'b0;
      par_q   <= 1'b0;
      dout_q  <= 8'h00;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      ord_q   <= ord_d;
      par_q   <= par_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end
  // valid defaults low so it is a single-cycle pulse even when en stays low
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    ord_d   = ord_q;
    par_d   = par_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    if (en) begin
      case (state_q)
        IDLE: if (!sin) begin
          state_d = DATA;
          cnt_d   = 3'd0;
          ord_d   = dir;
        end
        DATA: begin
          sr_d    = ord_q ? {sr_q[6:0], sin} : {sin, sr_q[7:1]};
          cnt_d   = cnt_q + 3'd1;
          state_d = (cnt_q == 3'd7) ? PARITY : DATA;
        end
        PARITY: begin
          par_d   = sin;
          state_d = STOP;
        end
        default: begin
          dout_d  = sr_q;
          valid_d = 1'b1;
          perr_d  = (^sr_q) ^ par_q;
          ferr_d  = ~sin;
          state_d = IDLE;
        end
      endcase
    end
  end
  assign dout  = dout_q;
  assign valid = valid_q;
  assign perr  = perr_q;
  assign ferr  = ferr_q;
  assign busy  = (state_q != IDLE);
endmodule

// File: tb/tb_shift_rx.sv
// tb_shift_rx: table-driven frame vectors plus hand-written reset and idle sequences for shift_rx.
module tb_shift_rx;
  logic       clk = 1'b0, clr = 1'b0, sin = 1'b1, en = 1'b0, dir = 1'b0;
  logic [7:0] dout;
  logic       valid, perr, ferr, busy;
  int         n_chk = 0, n_fail = 0;

  shift_rx dut (.clk(clk), .clr(clr), .sin(sin), .en(en), .dir(dir), .dout(dout),
                .valid(valid), .perr(perr), .ferr(ferr), .busy(busy));

  always #5 clk = ~clk;

  // w holds data bits in line order: w[7] is sent first
  typedef struct {
    logic       d;
    logic [7:0] w;
    logic       p;
    logic       s;
    int         gap;
    logic       tog;
    logic [7:0] e_dout;
    logic       e_perr;
    logic       e_ferr;
  } vec_t;

  vec_t v[11];
  int   n_valid, n_busy;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (valid === 1'b1) n_valid++;
    if (busy === 1'b1) n_busy++;
  endtask

  task automatic send_bit(input logic b, input int gap, input logic tg);
    en  = 1'b1;
    sin = b;
    if (tg) dir = ~dir;
    tick();
    for (int k = 1; k < gap; k++) begin
      en  = 1'b0;
      sin = ~b;
      tick();
    end
  endtask

  task automatic send_frame(input logic d, input logic [7:0] w, input logic p, input logic s,
                            input int gap, input logic tog);
    n_valid = 0;
    n_busy  = 0;
    dir = d;
    send_bit(1'b0, gap, 1'b0);
    for (int i = 7; i >= 0; i--) send_bit(w[i], gap, tog);
    send_bit(p, gap, tog);
    en  = 1'b1;
    sin = s;
    @(posedge clk);
    #1;
    if (valid === 1'b1) n_valid++;
    if (busy === 1'b1) n_busy++;
  endtask

  initial begin
    v[0]  = '{1'b1, 8'b10100101, 1'b0, 1'b1, 1, 1'b0, 8'hA5, 1'b0, 1'b0};
    v[1]  = '{1'b0, 8'b00111100, 1'b0, 1'b1, 1, 1'b0, 8'h3C, 1'b0, 1'b0};
    v[2]  = '{1'b1, 8'b00111100, 1'b0, 1'b1, 1, 1'b0, 8'h3C, 1'b0, 1'b0};
    v[3]  = '{1'b0, 8'b10000000, 1'b1, 1'b1, 1, 1'b0, 8'h01, 1'b0, 1'b0};
    v[4]  = '{1'b1, 8'b00000001, 1'b0, 1'b1, 1, 1'b0, 8'h01, 1'b1, 1'b0};
    v[5]  = '{1'b1, 8'b10100101, 1'b0, 1'b1, 1, 1'b0, 8'hA5, 1'b0, 1'b0};
    v[6]  = '{1'b1, 8'b11111111, 1'b0, 1'b0, 1, 1'b0, 8'hFF, 1'b0, 1'b1};
    v[7]  = '{1'b1, 8'b00000000, 1'b0, 1'b1, 1, 1'b0, 8'h00, 1'b0, 1'b0};
    v[8]  = '{1'b1, 8'b10100101, 1'b0, 1'b1, 3, 1'b0, 8'hA5, 1'b0, 1'b0};
    v[9]  = '{1'b1, 8'b10100101, 1'b0, 1'b1, 3, 1'b1, 8'hA5, 1'b0, 1'b0};
    v[10] = '{1'b0, 8'b11010000, 1'b1, 1'b1, 2, 1'b1, 8'h0B, 1'b0, 1'b0};

    #12;
    chk("reset_dout", dout, 8'h00);
    chk("reset_valid", valid, 0);
    chk("reset_perr", perr, 0);
    chk("reset_ferr", ferr, 0);
    chk("reset_busy", busy, 0);
    clr = 1'b1;
    en  = 1'b1;
    sin = 1'b1;
    tick();
    tick();
    en  = 1'b0;
    sin = 1'b0;
    tick();
    tick();
    chk("idle_en0_no_start", busy, 0);
    en  = 1'b1;
    sin = 1'b1;
    tick();

    // frames are applied back to back: each start bit lands on the edge after the previous stop
    for (int f = 0; f < 11; f++) begin
      send_frame(v[f].d, v[f].w, v[f].p, v[f].s, v[f].gap, v[f].tog);
      chk($sformatf("f%0d_valid_at_stop", f), valid, 1);
      chk($sformatf("f%0d_dout", f), dout, v[f].e_dout);
      chk($sformatf("f%0d_perr", f), perr, v[f].e_perr);
      chk($sformatf("f%0d_ferr", f), ferr, v[f].e_ferr);
      chk($sformatf("f%0d_valid_pulses", f), n_valid, 1);
      chk($sformatf("f%0d_busy_cycles", f), n_busy, 10 * v[f].gap);
      chk($sformatf("f%0d_busy_after_stop", f), busy, 0);
    end
    en  = 1'b0;
    sin = 1'b1;
    tick();
    chk("valid_drops_en0", valid, 0);
    chk("dout_holds", dout, 8'h0B);

    // reset mid-frame after 4 data bits
    n_valid = 0;
    dir = 1'b1;
    send_bit(1'b0, 1, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0], 1, 1'b0);
    chk("midframe_busy", busy, 1);
    #2;
    clr = 1'b0;
    #1;
    chk("async_rst_dout", dout, 8'h00);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_valid", valid, 0);
    chk("async_rst_perr", perr, 0);
    chk("async_rst_ferr", ferr, 0);
    en  = 1'b1;
    sin = 1'b1;
    tick();
    clr = 1'b1;
    tick();
    chk("abandoned_no_valid", n_valid, 0);
    send_frame(1'b1, 8'b01011010, 1'b0, 1'b1, 1, 1'b0);
    chk("post_rst_dout", dout, 8'h5A);
    chk("post_rst_valid_pulses", n_valid, 1);
    chk("post_rst_perr", perr, 0);
    chk("post_rst_ferr", ferr, 0);
    sin = 1'b1;
    tick();
    chk("post_rst_valid_drop", valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
